// File: rtl/vm_pkg.sv
// Shared types for the vending-machine dispense path.
// Contents: change-code constants, the queued dispense event, the dispense FSM
// state type, and a helper that maps a change code to a coin count.
package vm_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_RSVD = 2'b11;

    // One queued dispense job: optional product drop followed by 0..2 coins.
    typedef struct packed {
        logic       vend;
        logic [1:0] coins;
    } disp_evt_t;

    localparam int unsigned EVT_W = $bits(disp_evt_t);

    typedef enum logic [1:0] {
        StIdle,
        StMotor,
        StHopper,
        StFault
    } disp_state_e;

    function automatic logic [1:0] chg_to_coins(input logic [1:0] chg);
        logic [1:0] coins;
        case (chg)
            CHG_NONE: coins = 2'd0;
            CHG_5:    coins = 2'd1;
            CHG_10:   coins = 2'd2;
            CHG_RSVD: coins = 2'd0;  // reserved code carries no coins
            default:  coins = 2'd0;
        endcase
        return coins;
    endfunction

endpackage

// File: rtl/dispense_fifo.sv
// Synchronous FIFO of dispense events, show-ahead read (rdata is the head).
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes contents)
//   push, wdata     write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop             read request; ignored when empty
//   rdata           head entry, valid while !empty
//   full, empty     occupancy flags
module dispense_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot this edge, so a full FIFO can still take a push.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);  // DEPTH is a power of 2: natural wrap
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dispense_controller.sv
// Dispense controller: queues vend/change events from the coin FSM and drives
// the product motor and coin hopper through request/done handshakes with a
// timeout fault.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   b, change     vend pulse and change code from vending_machine
//   motor_done    product drop completed (pulse)
//   hopper_done   one coin ejected (pulse)
//   fault_clr     leave the fault state (pulse)
//   motor_on      product motor request (level)
//   hopper_req    coin eject request (level, held across multiple coins)
//   busy          FSM not idle or events pending
//   fault         timeout fault active
//   overflow      sticky: an event was dropped on a full queue
//   vend_count    completed product drops, saturating
module dispense_controller
    import vm_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic [1:0]       change,
    input  logic             motor_done,
    input  logic             hopper_done,
    input  logic             fault_clr,
    output logic             motor_on,
    output logic             hopper_req,
    output logic             busy,
    output logic             fault,
    output logic             overflow,
    output logic [CNT_W-1:0] vend_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    disp_state_e      state_q, state_d;
    logic             motor_on_q, motor_on_d;
    logic             hopper_req_q, hopper_req_d;
    logic             fault_q, fault_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       coins_q, coins_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    disp_evt_t        push_evt;
    disp_evt_t        pop_evt;
    logic [EVT_W-1:0] pop_raw;
    logic             evt_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign push_evt.vend  = b;
    assign push_evt.coins = chg_to_coins(change);
    assign evt_push       = b | (push_evt.coins != 2'd0);
    assign pop_evt        = disp_evt_t'(pop_raw);

    dispense_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_push),
        .wdata (push_evt),
        .pop   (fifo_pop),
        .rdata (pop_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        motor_on_d   = motor_on_q;
        hopper_req_d = hopper_req_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        coins_d      = coins_q;
        tmo_d        = tmo_q;
        fifo_pop     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    coins_d  = pop_evt.coins;
                    tmo_d    = '0;
                    if (pop_evt.vend) begin
                        state_d    = StMotor;
                        motor_on_d = 1'b1;
                    end else if (pop_evt.coins != 2'd0) begin
                        state_d      = StHopper;
                        hopper_req_d = 1'b1;
                    end
                end
            end
            StMotor: begin
                // done takes priority over a coincident timeout
                if (motor_done) begin
                    tmo_d      = '0;
                    motor_on_d = 1'b0;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (coins_q != 2'd0) begin
                        state_d      = StHopper;
                        hopper_req_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = StFault;
                    motor_on_d = 1'b0;
                    fault_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StHopper: begin
                if (hopper_done) begin
                    tmo_d   = '0;
                    coins_d = coins_q - 2'd1;
                    if (coins_q <= 2'd1) begin
                        state_d      = StIdle;
                        hopper_req_d = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d      = StFault;
                    hopper_req_d = 1'b0;
                    fault_d      = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StFault: begin
                // the interrupted event is abandoned; queued events resume
                if (fault_clr) begin
                    state_d = StIdle;
                    fault_d = 1'b0;
                    coins_d = 2'd0;
                    tmo_d   = '0;
                end
            end
            default: begin
                state_d      = StIdle;
                motor_on_d   = 1'b0;
                hopper_req_d = 1'b0;
            end
        endcase

        overflow_d = overflow_q | (evt_push & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            motor_on_q   <= 1'b0;
            hopper_req_q <= 1'b0;
            fault_q      <= 1'b0;
            overflow_q   <= 1'b0;
            cnt_q        <= '0;
            coins_q      <= 2'd0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            motor_on_q   <= motor_on_d;
            hopper_req_q <= hopper_req_d;
            fault_q      <= fault_d;
            overflow_q   <= overflow_d;
            cnt_q        <= cnt_d;
            coins_q      <= coins_d;
            tmo_q        <= tmo_d;
        end
    end

    assign motor_on   = motor_on_q;
    assign hopper_req = hopper_req_q;
    assign fault      = fault_q;
    assign overflow   = overflow_q;
    assign vend_count = cnt_q;
    assign busy       = (state_q != StIdle) | ~fifo_empty;

endmodule
